// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        RESP
    } arb_state_e;

    typedef enum logic {
        SRC_I,
        SRC_D
    } arb_src_e;

    localparam int TIMEOUT_CYCLES_DEFAULT = 64;

    // Width of the counter that tracks BUSY cycles spent waiting for mem_ready.
    function automatic int timeout_cnt_width(input int cycles);
        return $clog2(cycles);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_timeout.sv
// Clear/enable BUSY-cycle counter with a terminal-count flag at TIMEOUT_CYCLES-1.
module arb_timeout_ctr
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int CNT_W = timeout_cnt_width(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear wins over enable so a fresh access always starts counting from zero.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the fetch port and the data port.
// Data wins ties; each access is IDLE -> BUSY_x -> RESP with a one-cycle valid.
// Optional macro MEM_ARB_FAIR_EN: after MAX_D_STREAK data grants made while a
// fetch is waiting, the next IDLE grant goes to fetch.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
    parameter int MAX_D_STREAK   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_valid,
    output logic                  if_stall,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_valid,
    output logic                  d_stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready,
    output logic                  bus_err
);

    if (TIMEOUT_CYCLES < 2 || MAX_D_STREAK < 1) begin : g_param_check
        $error("mem_port_arbiter: TIMEOUT_CYCLES must be >= 2 and MAX_D_STREAK >= 1");
    end

    arb_state_e            state_q, state_d;
    arb_src_e              src_q, src_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  err_q, err_d;
    logic                  to_clear;
    logic                  to_enable;
    logic                  to_tc;
    logic                  fetch_forced;

`ifdef MEM_ARB_FAIR_EN
    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);

    logic [STREAK_W-1:0] streak_q, streak_d;

    assign fetch_forced = if_req && (streak_q == STREAK_W'(MAX_D_STREAK));

    // Count data grants that overtook a waiting fetch; any fetch grant clears it.
    always_comb begin
        streak_d = streak_q;
        if (state_q == IDLE) begin
            if (d_req && !fetch_forced) begin
                if (if_req) begin
                    streak_d = streak_q + STREAK_W'(1);
                end
            end else if (if_req) begin
                streak_d = '0;
            end
        end
    end

    // Streak register.
    always_ff @(posedge clk) begin
        if (reset) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end
`else
    assign fetch_forced = 1'b0;
`endif

    arb_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (to_clear),
        .enable (to_enable),
        .tc     (to_tc)
    );

    // Grant in IDLE, wait for mem_ready (or abort on timeout) in BUSY, pulse valid in RESP.
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        err_d      = err_q;
        to_clear   = 1'b0;
        to_enable  = 1'b0;

        case (state_q)
            IDLE: begin
                to_clear = 1'b1;
                err_d    = 1'b0;
                if (d_req && !fetch_forced) begin
                    state_d = BUSY_D;
                    src_d   = SRC_D;
                    addr_d  = d_addr;
                    we_d    = d_we;
                    wdata_d = d_wdata;
                end else if (if_req) begin
                    state_d = BUSY_I;
                    src_d   = SRC_I;
                    addr_d  = if_addr;
                    we_d    = 1'b0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready) begin
                    to_clear = 1'b1;
                    state_d  = RESP;
                    if (state_q == BUSY_I) begin
                        if_rdata_d = mem_rdata;
                    end else if (!we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                end else if (to_tc) begin
                    to_clear = 1'b1;
                    state_d  = RESP;
                    err_d    = 1'b1;
                    if (state_q == BUSY_I) begin
                        if_rdata_d = '0;
                    end else begin
                        d_rdata_d = '0;
                    end
                end else begin
                    to_enable = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched request and response registers; reset abandons any access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            src_q      <= SRC_I;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            err_q      <= err_d;
        end
    end

    assign mem_req   = (state_q == BUSY_I) || (state_q == BUSY_D);
    assign mem_we    = (state_q == BUSY_D) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_valid  = (state_q == RESP) && (src_q == SRC_I);
    assign d_valid   = (state_q == RESP) && (src_q == SRC_D);
    assign bus_err   = (state_q == RESP) && err_q;

    assign if_stall  = if_req && !if_valid && !reset;
    assign d_stall   = d_req && !d_valid && !reset;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a scoreboard of expected accesses.
// Honors MEM_ARB_FAIR_EN for the grant-order check.
module tb_mem_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          if_stall;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_valid;
    logic          d_stall;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          bus_err;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;
    int          ready_wait = 0;
    bit          never_ready = 1'b0;
    int          busy_cnt = 0;
    logic [31:0] model_d_rdata = '0;
    logic [31:0] model_i_rdata = '0;

    mem_port_arbiter #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (8),
        .MAX_D_STREAK   (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .if_stall  (if_stall),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_valid   (d_valid),
        .d_stall   (d_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_rdata(input logic [31:0] a);
        if (a == 32'h10) return 32'h0050_0093;
        return {a[15:0], ~a[15:0]};
    endfunction

    // Memory model: mem_ready rises after ready_wait BUSY cycles unless never_ready.
    always @(posedge clk) begin
        if (mem_req && !mem_ready) busy_cnt <= busy_cnt + 1;
        else busy_cnt <= 0;
    end

    assign mem_ready = mem_req && !never_ready && (busy_cnt >= ready_wait);
    assign mem_rdata = mem_ready ? model_rdata(mem_addr) : 32'hBAD0_BAD0;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic void pushExp(input bit is_d, input bit we, input logic [31:0] addr,
                                    input logic [31:0] wdata, input bit err);
        exp_t e;
        e.is_d  = is_d;
        e.we    = is_d & we;
        e.addr  = addr;
        e.wdata = wdata;
        e.err   = err;
        if (err) e.rdata = '0;
        else if (is_d && we) e.rdata = model_d_rdata;
        else e.rdata = model_rdata(addr);
        if (is_d) model_d_rdata = e.rdata;
        else model_i_rdata = e.rdata;
        sb.push_back(e);
    endfunction

    // Scoreboard monitor: memory side against the head entry, completions pop it.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_req) begin
                if (sb.size() == 0) begin
                    checkOutput("mem_req_unexpected", 64'(mem_req), 64'd0);
                end else begin
                    checkOutput("mem_addr", 64'(mem_addr), 64'(sb[0].addr));
                    checkOutput("mem_we", 64'(mem_we), 64'(sb[0].we));
                    if (sb[0].we) checkOutput("mem_wdata", 64'(mem_wdata), 64'(sb[0].wdata));
                end
            end
            if (if_valid || d_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("valid_unexpected", 64'({if_valid, d_valid}), 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("valid_port", 64'(d_valid), 64'(mon_e.is_d));
                    checkOutput("valid_both", 64'(if_valid & d_valid), 64'd0);
                    if (mon_e.is_d) checkOutput("d_rdata", 64'(d_rdata), 64'(mon_e.rdata));
                    else checkOutput("if_rdata", 64'(if_rdata), 64'(mon_e.rdata));
                    checkOutput("bus_err", 64'(bus_err), 64'(mon_e.err));
                end
            end else if (bus_err) begin
                checkOutput("bus_err_stray", 64'(bus_err), 64'd0);
            end
        end
    end

    task automatic waitValid(input bit is_d, input int budget);
        bit seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (is_d ? d_valid : if_valid) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput(is_d ? "d_valid_seen" : "if_valid_seen", 64'(seen), 64'd1);
    endtask

    task automatic applyStimulus(input bit is_d, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        @(posedge clk); #1;
        pushExp(is_d, we, addr, wdata, 1'b0);
        if (is_d) begin
            d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
        end else begin
            if_addr = addr; if_req = 1'b1;
        end
        waitValid(is_d, 200);
        d_req = 1'b0; if_req = 1'b0; d_we = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit order[6];
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

        // Reset behaviour: stalls held low even with requests present.
        repeat (3) @(posedge clk);
        #1; if_req = 1'b1; d_req = 1'b1;
        @(negedge clk);
        checkOutput("rst_if_stall", 64'(if_stall), 64'd0);
        checkOutput("rst_d_stall", 64'(d_stall), 64'd0);
        checkOutput("rst_mem_req", 64'(mem_req), 64'd0);
        @(posedge clk); #1; if_req = 1'b0; d_req = 1'b0; reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_if_valid", 64'(if_valid), 64'd0);
        checkOutput("rst_d_valid", 64'(d_valid), 64'd0);
        checkOutput("rst_bus_err", 64'(bus_err), 64'd0);
        checkOutput("rst_if_rdata", 64'(if_rdata), 64'd0);
        checkOutput("rst_d_rdata", 64'(d_rdata), 64'd0);

        // Single fetch, memory always ready.
        $display("[TB] single fetch");
        @(posedge clk); #1; if_addr = 32'h10; if_req = 1'b1; pushExp(1'b0, 1'b0, 32'h10, '0, 1'b0);
        @(negedge clk);
        checkOutput("t1_c0_mem_req", 64'(mem_req), 64'd0);
        checkOutput("t1_c0_if_stall", 64'(if_stall), 64'd1);
        @(negedge clk);
        checkOutput("t1_c1_mem_req", 64'(mem_req), 64'd1);
        checkOutput("t1_c1_if_stall", 64'(if_stall), 64'd1);
        @(negedge clk);
        checkOutput("t1_c2_if_valid", 64'(if_valid), 64'd1);
        checkOutput("t1_c2_if_rdata", 64'(if_rdata), 64'h0050_0093);
        checkOutput("t1_c2_if_stall", 64'(if_stall), 64'd0);
        if_req = 1'b0;

        // Simultaneous requests: data first, then fetch.
        $display("[TB] simultaneous requests");
        @(posedge clk); #1;
        if_addr = 32'h40; if_req = 1'b1; d_addr = 32'h100; d_we = 1'b0; d_req = 1'b1;
        pushExp(1'b1, 1'b0, 32'h100, '0, 1'b0);
        pushExp(1'b0, 1'b0, 32'h40, '0, 1'b0);
        @(negedge clk);
        checkOutput("t2_c0_d_stall", 64'(d_stall), 64'd1);
        @(negedge clk);
        checkOutput("t2_c1_mem_req", 64'(mem_req), 64'd1);
        checkOutput("t2_c1_mem_addr", 64'(mem_addr), 64'h100);
        @(negedge clk);
        checkOutput("t2_c2_d_valid", 64'(d_valid), 64'd1);
        checkOutput("t2_c2_if_valid", 64'(if_valid), 64'd0);
        d_req = 1'b0;
        @(negedge clk);
        checkOutput("t2_c3_mem_req", 64'(mem_req), 64'd0);
        checkOutput("t2_c3_if_stall", 64'(if_stall), 64'd1);
        @(negedge clk);
        checkOutput("t2_c4_mem_req", 64'(mem_req), 64'd1);
        checkOutput("t2_c4_mem_addr", 64'(mem_addr), 64'h40);
        @(negedge clk);
        checkOutput("t2_c5_if_valid", 64'(if_valid), 64'd1);
        if_req = 1'b0;

        // Store with memory ready on the third BUSY cycle; inputs change after grant.
        $display("[TB] store with wait states");
        ready_wait = 2;
        @(posedge clk); #1;
        d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1;
        pushExp(1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        @(posedge clk); #1; d_addr = 32'h999; d_wdata = 32'h0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checkOutput("t3_mem_req", 64'(mem_req), 64'd1);
            checkOutput("t3_mem_we", 64'(mem_we), 64'd1);
            checkOutput("t3_mem_ready", 64'(mem_ready), 64'(k == 3));
            checkOutput("t3_d_valid_early", 64'(d_valid), 64'd0);
        end
        @(negedge clk);
        checkOutput("t3_d_valid", 64'(d_valid), 64'd1);
        checkOutput("t3_d_rdata_kept", 64'(d_rdata), 64'h0100_FEFF);
        d_req = 1'b0; d_we = 1'b0;

        // Timeout: memory never answers.
        $display("[TB] timeout");
        never_ready = 1'b1;
        @(posedge clk); #1;
        d_addr = 32'h300; d_req = 1'b1; pushExp(1'b1, 1'b0, 32'h300, '0, 1'b1);
        @(negedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checkOutput("t4_busy_mem_req", 64'(mem_req), 64'd1);
            checkOutput("t4_busy_no_valid", 64'(d_valid), 64'd0);
        end
        @(negedge clk);
        checkOutput("t4_d_valid", 64'(d_valid), 64'd1);
        checkOutput("t4_bus_err", 64'(bus_err), 64'd1);
        checkOutput("t4_d_rdata_zero", 64'(d_rdata), 64'd0);
        d_req = 1'b0;
        never_ready = 1'b0; ready_wait = 0;
        applyStimulus(1'b1, 1'b0, 32'h310, '0);

        // Reset during BUSY_D abandons the access.
        $display("[TB] reset mid-access");
        ready_wait = 5;
        @(posedge clk); #1;
        d_addr = 32'h400; d_req = 1'b1; pushExp(1'b1, 1'b0, 32'h400, '0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t5_busy_mem_req", 64'(mem_req), 64'd1);
        @(posedge clk); #1; reset = 1'b1;
        @(negedge clk);
        checkOutput("t5_sync_reset_mem_req", 64'(mem_req), 64'd1);
        @(posedge clk); #1; reset = 1'b0; d_req = 1'b0;
        @(negedge clk);
        checkOutput("t5_after_rst_mem_req", 64'(mem_req), 64'd0);
        checkOutput("t5_after_rst_d_valid", 64'(d_valid), 64'd0);
        checkOutput("t5_after_rst_d_rdata", 64'(d_rdata), 64'd0);
        sb.delete(0);
        model_d_rdata = '0; model_i_rdata = '0;
        repeat (6) begin
            @(negedge clk);
            checkOutput("t5_no_late_valid", 64'(d_valid), 64'd0);
        end
        ready_wait = 1;
        applyStimulus(1'b1, 1'b0, 32'h500, '0);
        applyStimulus(1'b0, 1'b0, 32'h20, '0);

        // Mixed random traffic.
        $display("[TB] random traffic");
        for (int i = 0; i < 6; i++) begin
            ready_wait = int'($urandom_range(0, 3));
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          32'($urandom_range(0, 1023)) << 2, 32'($urandom));
        end

        // Both requests held high: grant order.
        $display("[TB] grant order");
        ready_wait = 0;
`ifdef MEM_ARB_FAIR_EN
        order = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
`else
        order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            pushExp(order[i], 1'b0, order[i] ? 32'h600 : 32'h80, '0, 1'b0);
        end
        d_addr = 32'h600; d_we = 1'b0; d_req = 1'b1; if_addr = 32'h80; if_req = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk); #1;
            if (sb.size() == 0) break;
        end
        checkOutput("t6_all_served", 64'(sb.size()), 64'd0);
        d_req = 1'b0; if_req = 1'b0;

        repeat (4) @(negedge clk);
        checkOutput("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
